// File: rtl/classifier_helpers_band_energy_pkg.sv
// Shared types and sizing helpers for the band-energy stage.
package classifier_helpers_band_energy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Accumulator width that holds n_samples full-scale magnitudes without overflow.
    function automatic int unsigned acc_width(input int unsigned bit_width,
                                              input int unsigned n_samples);
        return bit_width + $clog2(n_samples);
    endfunction

endpackage

// File: rtl/classifier_helpers_BandCompare.sv
// Inclusive unsigned band check: lo <= f <= hi. An inverted band never matches.
module classifier_helpers_BandCompare #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic [BIT_WIDTH-1:0] i_lo,
    input  logic [BIT_WIDTH-1:0] i_hi,
    input  logic [BIT_WIDTH-1:0] i_freq,
    output logic                 o_in_band_c
);

    assign o_in_band_c = (i_freq >= i_lo) && (i_freq <= i_hi);

endmodule

// File: rtl/classifier_helpers_band_energy.sv
// Sums FFT magnitudes of bins inside [cutoff_lo, cutoff_hi], one bin per cycle,
// and reports the band energy with a threshold decision over val/rdy.
module classifier_helpers_band_energy
    import classifier_helpers_band_energy_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              recv_val,
    output logic                                              recv_rdy,
    input  logic [BIT_WIDTH-1:0]                              recv_mag     [N_SAMPLES],
    input  logic [BIT_WIDTH-1:0]                              frequency_in [N_SAMPLES],
    input  logic [BIT_WIDTH-1:0]                              cutoff_lo,
    input  logic [BIT_WIDTH-1:0]                              cutoff_hi,
    input  logic [acc_width(BIT_WIDTH, N_SAMPLES)-1:0]        threshold,
    output logic                                              send_val,
    input  logic                                              send_rdy,
    output logic [acc_width(BIT_WIDTH, N_SAMPLES)-1:0]        send_energy,
    output logic                                              send_class
);

    localparam int unsigned ACC_W = acc_width(BIT_WIDTH, N_SAMPLES);
    localparam int unsigned IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

    generate
        if (N_SAMPLES < 2 || (N_SAMPLES & (N_SAMPLES - 1)) != 0) begin : g_bad_n_samples
            $error("N_SAMPLES must be a power of 2 and at least 2");
        end
    endgenerate

    state_e               r_state;
    state_e               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_acc_nxt;
    logic [BIT_WIDTH-1:0] r_mag  [N_SAMPLES];
    logic [BIT_WIDTH-1:0] r_freq [N_SAMPLES];
    logic [BIT_WIDTH-1:0] r_lo;
    logic [BIT_WIDTH-1:0] r_hi;
    logic [ACC_W-1:0]     r_threshold;
    logic                 r_recv_rdy;
    logic                 r_send_val;
    logic [ACC_W-1:0]     r_send_energy;
    logic                 r_send_class;
    logic                 w_in_band;
    logic                 w_capture;
    logic                 w_last;
    logic                 w_recv_rdy_nxt;
    logic                 w_send_val_nxt;

    classifier_helpers_BandCompare #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_band_compare (
        .i_lo        (r_lo),
        .i_hi        (r_hi),
        .i_freq      (r_freq[r_idx]),
        .o_in_band_c (w_in_band)
    );

    assign w_acc_nxt = r_acc + (w_in_band ? ACC_W'(r_mag[r_idx]) : '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (recv_val && r_recv_rdy)   w_state_nxt = ACCUM;
            ACCUM:   if (r_idx == IDX_LAST)        w_state_nxt = DONE;
            DONE:    if (r_send_val && send_rdy)   w_state_nxt = IDLE;
            default:                               w_state_nxt = IDLE;
        endcase
    end

    // Output / control decode; handshake flags are registered from the next state
    always_comb begin
        w_capture      = 1'b0;
        w_last         = 1'b0;
        w_recv_rdy_nxt = (w_state_nxt == IDLE);
        w_send_val_nxt = (w_state_nxt == DONE);
        if (r_state == IDLE && recv_val && r_recv_rdy) begin
            w_capture = 1'b1;
        end
        if (r_state == ACCUM && r_idx == IDX_LAST) begin
            w_last = 1'b1;
        end
    end

    // Datapath and output registers; the final bin lands directly in the result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_acc         <= '0;
            r_recv_rdy    <= 1'b1;
            r_send_val    <= 1'b0;
            r_send_energy <= '0;
            r_send_class  <= 1'b0;
        end else begin
            r_recv_rdy <= w_recv_rdy_nxt;
            r_send_val <= w_send_val_nxt;
            if (w_capture) begin
                r_idx <= '0;
                r_acc <= '0;
            end else if (r_state == ACCUM) begin
                r_idx <= r_idx + IDX_W'(1);
                r_acc <= w_acc_nxt;
            end
            if (w_last) begin
                r_send_energy <= w_acc_nxt;
                r_send_class  <= (w_acc_nxt > r_threshold);
            end
        end
    end

    // Frame snapshot: later input changes cannot disturb the frame in flight
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mag       <= recv_mag;
            r_freq      <= frequency_in;
            r_lo        <= cutoff_lo;
            r_hi        <= cutoff_hi;
            r_threshold <= threshold;
        end
    end

    assign recv_rdy    = r_recv_rdy;
    assign send_val    = r_send_val;
    assign send_energy = r_send_energy;
    assign send_class  = r_send_class;

endmodule
